// File: rtl/wb_stage_if.sv
// Writeback-stage bus bundle: execute results and memory responses in,
// register-file write ports, forwarding info, stall and load-queue status out.
interface wb_stage_if;
    logic        ixu1_ex_valid;
    logic [4:0]  ixu1_ex_rd;
    logic [31:0] ixu1_ex_data;
    logic        ixu2_ex_valid;
    logic [4:0]  ixu2_ex_rd;
    logic [31:0] ixu2_ex_data;
    logic        lsu_ex_valid;
    logic        lsu_ex_is_load;
    logic [4:0]  lsu_ex_rd;
    logic [31:0] lsu_ex_data;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    logic [4:0]  ixu1_wb_rd;
    logic [31:0] ixu1_wb_data;
    logic        ixu1_rf_we;
    logic [4:0]  ixu2_wb_rd;
    logic [31:0] ixu2_wb_data;
    logic        ixu2_rf_we;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        lsu_wb_is_load;
    logic        lsu_rf_we;
    logic        lsu_stall;
    logic [31:0] load_pending_mask;
    logic        lq_err;

    modport master (
        output ixu1_ex_valid, ixu1_ex_rd, ixu1_ex_data,
        output ixu2_ex_valid, ixu2_ex_rd, ixu2_ex_data,
        output lsu_ex_valid, lsu_ex_is_load, lsu_ex_rd, lsu_ex_data,
        output mem_rsp_valid, mem_rsp_data,
        input  ixu1_wb_rd, ixu1_wb_data, ixu1_rf_we,
        input  ixu2_wb_rd, ixu2_wb_data, ixu2_rf_we,
        input  lsu_wb_rd, lsu_wb_data, lsu_wb_is_load, lsu_rf_we,
        input  lsu_stall, load_pending_mask, lq_err
    );

    modport slave (
        input  ixu1_ex_valid, ixu1_ex_rd, ixu1_ex_data,
        input  ixu2_ex_valid, ixu2_ex_rd, ixu2_ex_data,
        input  lsu_ex_valid, lsu_ex_is_load, lsu_ex_rd, lsu_ex_data,
        input  mem_rsp_valid, mem_rsp_data,
        output ixu1_wb_rd, ixu1_wb_data, ixu1_rf_we,
        output ixu2_wb_rd, ixu2_wb_data, ixu2_rf_we,
        output lsu_wb_rd, lsu_wb_data, lsu_wb_is_load, lsu_rf_we,
        output lsu_stall, load_pending_mask, lq_err
    );
endinterface

// File: rtl/wb_stage.sv
// VLIW writeback stage: IXU1/IXU2/LSU result registers plus an in-order queue of
// outstanding load destinations. Macro WB_LOAD_PENDING_MASK_EN builds the pending mask.
module wb_stage #(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);
    localparam int unsigned PW = $clog2(LQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [4:0]  r_ixu1_rd;
    logic [31:0] r_ixu1_data;
    logic [4:0]  r_ixu2_rd;
    logic [31:0] r_ixu2_data;
    logic [4:0]  r_lsu_rd;
    logic [31:0] r_lsu_data;
    logic        r_lsu_is_load;

    logic [4:0]  r_lq [LQ_DEPTH];
    ptr_t        r_wptr;
    ptr_t        r_rptr;
    cnt_t        r_count;

    logic        r_hold_v;
    logic [4:0]  r_hold_rd;
    logic [31:0] r_hold_data;
    logic        r_lq_err;

    logic        w_full;
    logic        w_stall;
    logic        w_push;
    logic        w_pop;
    logic        w_orphan;
    logic        w_nl_acc;
    logic [4:0]  w_head;
    logic [4:0]  w_lsu_rd_n;
    logic [31:0] w_lsu_data_n;
    logic        w_lsu_is_load_n;
    logic [31:0] w_lsu_ex_data_m;
    logic [31:0] w_mask;

    assign w_full   = (r_count == cnt_t'(LQ_DEPTH));
    assign w_stall  = r_hold_v |
                      (w_full & bus.lsu_ex_valid & bus.lsu_ex_is_load & ~bus.mem_rsp_valid);
    assign w_push   = bus.lsu_ex_valid & bus.lsu_ex_is_load & ~w_stall;
    assign w_pop    = bus.mem_rsp_valid & (r_count != '0);
    assign w_orphan = bus.mem_rsp_valid & (r_count == '0);
    assign w_nl_acc = bus.lsu_ex_valid & ~bus.lsu_ex_is_load & ~w_stall;
    assign w_head   = r_lq[r_rptr];
    assign w_lsu_ex_data_m = (bus.lsu_ex_rd != '0) ? bus.lsu_ex_data : '0;

    // IXU slots: plain pipeline registers, data zeroed for rd=x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ixu1_rd   <= '0;
            r_ixu1_data <= '0;
            r_ixu2_rd   <= '0;
            r_ixu2_data <= '0;
        end else begin
            r_ixu1_rd   <= bus.ixu1_ex_valid ? bus.ixu1_ex_rd : '0;
            r_ixu1_data <= (bus.ixu1_ex_valid && bus.ixu1_ex_rd != '0) ? bus.ixu1_ex_data : '0;
            r_ixu2_rd   <= bus.ixu2_ex_valid ? bus.ixu2_ex_rd : '0;
            r_ixu2_data <= (bus.ixu2_ex_valid && bus.ixu2_ex_rd != '0) ? bus.ixu2_ex_data : '0;
        end
    end

    // LSU slot arbitration: load response, then parked result, then direct result
    always_comb begin
        w_lsu_rd_n      = '0;
        w_lsu_data_n    = '0;
        w_lsu_is_load_n = 1'b0;
        if (w_pop) begin
            w_lsu_rd_n      = w_head;
            w_lsu_data_n    = (w_head != '0) ? bus.mem_rsp_data : '0;
            w_lsu_is_load_n = 1'b1;
        end else if (r_hold_v) begin
            w_lsu_rd_n   = r_hold_rd;
            w_lsu_data_n = r_hold_data;
        end else if (w_nl_acc) begin
            w_lsu_rd_n   = bus.lsu_ex_rd;
            w_lsu_data_n = w_lsu_ex_data_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lsu_rd      <= '0;
            r_lsu_data    <= '0;
            r_lsu_is_load <= 1'b0;
            r_hold_v      <= 1'b0;
            r_hold_rd     <= '0;
            r_hold_data   <= '0;
            r_lq_err      <= 1'b0;
        end else begin
            r_lsu_rd      <= w_lsu_rd_n;
            r_lsu_data    <= w_lsu_data_n;
            r_lsu_is_load <= w_lsu_is_load_n;
            // A parked result can never coincide with an accepted one: hold forces stall
            if (w_pop && w_nl_acc) begin
                r_hold_v    <= 1'b1;
                r_hold_rd   <= bus.lsu_ex_rd;
                r_hold_data <= w_lsu_ex_data_m;
            end else if (!w_pop && r_hold_v) begin
                r_hold_v <= 1'b0;
            end
            if (w_orphan) begin
                r_lq_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ptr_t'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lq[r_wptr] <= bus.lsu_ex_rd;
        end
    end

`ifdef WB_LOAD_PENDING_MASK_EN
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (cnt_t'(i) < r_count) begin
                w_mask[r_lq[r_rptr + ptr_t'(i)]] = 1'b1;
            end
        end
        w_mask[0] = 1'b0;
    end
`else
    assign w_mask = '0;
`endif

    assign bus.ixu1_wb_rd        = r_ixu1_rd;
    assign bus.ixu1_wb_data      = r_ixu1_data;
    assign bus.ixu1_rf_we        = (r_ixu1_rd != '0);
    assign bus.ixu2_wb_rd        = r_ixu2_rd;
    assign bus.ixu2_wb_data      = r_ixu2_data;
    assign bus.ixu2_rf_we        = (r_ixu2_rd != '0);
    assign bus.lsu_wb_rd         = r_lsu_rd;
    assign bus.lsu_wb_data       = r_lsu_data;
    assign bus.lsu_wb_is_load    = r_lsu_is_load;
    assign bus.lsu_rf_we         = (r_lsu_rd != '0);
    assign bus.lsu_stall         = w_stall;
    assign bus.load_pending_mask = w_mask;
    assign bus.lq_err            = r_lq_err;
endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized checks of wb_stage against a queue-based reference model.
module tb_wb_stage;
    localparam int unsigned DEPTH = 4;
`ifdef WB_LOAD_PENDING_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_stage_if bus ();
    wb_stage #(.LQ_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int          q[$];
    bit          m_hold_v;
    logic [4:0]  m_hold_rd;
    logic [31:0] m_hold_data;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mexp(input logic [31:0] m);
        return MASK_ON ? m : 32'h0;
    endfunction

    task automatic idle();
        bus.ixu1_ex_valid = 0; bus.ixu1_ex_rd = 0; bus.ixu1_ex_data = 0;
        bus.ixu2_ex_valid = 0; bus.ixu2_ex_rd = 0; bus.ixu2_ex_data = 0;
        bus.lsu_ex_valid = 0; bus.lsu_ex_is_load = 0; bus.lsu_ex_rd = 0; bus.lsu_ex_data = 0;
        bus.mem_rsp_valid = 0; bus.mem_rsp_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu_op(input bit ld, input logic [4:0] rd, input logic [31:0] d);
        bus.lsu_ex_valid = 1; bus.lsu_ex_is_load = ld; bus.lsu_ex_rd = rd; bus.lsu_ex_data = d;
    endtask

    task automatic chk_lsu(input string tag, input logic [4:0] rd, input logic [31:0] d, input bit ld);
        chk({tag, ".rd"}, bus.lsu_wb_rd, rd);
        chk({tag, ".data"}, bus.lsu_wb_data, d);
        chk({tag, ".is_load"}, bus.lsu_wb_is_load, ld);
        chk({tag, ".we"}, bus.lsu_rf_we, rd != 0);
    endtask

    initial begin
        logic        lv, il, rsp, ev;
        logic [4:0]  lrd, er;
        logic [31:0] ld, ed, m;
        bit          prev_stall, e_stall, push, pop, nl;
        logic        v1, v2;
        logic [4:0]  rd1, rd2;
        logic [31:0] d1, d2;
        int          h;

        idle();
        rst_n = 0;
        #12;
        chk("rst.ixu1_rd", bus.ixu1_wb_rd, 0);
        chk("rst.ixu1_data", bus.ixu1_wb_data, 0);
        chk("rst.ixu1_we", bus.ixu1_rf_we, 0);
        chk("rst.ixu2_we", bus.ixu2_rf_we, 0);
        chk_lsu("rst.lsu", 0, 0, 0);
        chk("rst.mask", bus.load_pending_mask, 0);
        chk("rst.err", bus.lq_err, 0);
        chk("rst.stall", bus.lsu_stall, 0);
        @(negedge clk);
        rst_n = 1;
        step();

        // IXU writeback
        bus.ixu1_ex_valid = 1; bus.ixu1_ex_rd = 5; bus.ixu1_ex_data = 32'hDEAD;
        bus.ixu2_ex_valid = 1; bus.ixu2_ex_rd = 0; bus.ixu2_ex_data = 32'h1234;
        step();
        idle();
        chk("ixu1.rd", bus.ixu1_wb_rd, 5);
        chk("ixu1.data", bus.ixu1_wb_data, 32'hDEAD);
        chk("ixu1.we", bus.ixu1_rf_we, 1);
        chk("ixu2.rd", bus.ixu2_wb_rd, 0);
        chk("ixu2.data", bus.ixu2_wb_data, 0);
        chk("ixu2.we", bus.ixu2_rf_we, 0);

        // load path
        lsu_op(1, 7, 0);
        #1 chk("load.stall", bus.lsu_stall, 0);
        step();
        idle();
        chk("load.mask_set", bus.load_pending_mask, mexp(32'h80));
        step();
        step();
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hCAFE;
        step();
        idle();
        chk_lsu("load.wb", 7, 32'hCAFE, 1);
        chk("load.mask_clr", bus.load_pending_mask, 0);

        // response vs non-load collision
        lsu_op(1, 9, 0);
        step();
        idle();
        lsu_op(0, 3, 32'h11);
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h99;
        #1 chk("coll.stall0", bus.lsu_stall, 0);
        step();
        idle();
        chk_lsu("coll.load", 9, 32'h99, 1);
        chk("coll.stall1", bus.lsu_stall, 1);
        step();
        chk_lsu("coll.nl", 3, 32'h11, 0);
        chk("coll.stall2", bus.lsu_stall, 0);

        // full queue
        for (int r = 1; r <= 4; r++) begin
            lsu_op(1, 5'(r), 0);
            #1 chk("full.fill_stall", bus.lsu_stall, 0);
            step();
        end
        idle();
        lsu_op(1, 5, 0);
        #1 chk("full.stall", bus.lsu_stall, 1);
        chk("full.mask", bus.load_pending_mask, mexp(32'h1E));
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hAAAA;
        #1 chk("full.pushpop_stall", bus.lsu_stall, 0);
        step();
        idle();
        chk_lsu("full.pop1", 1, 32'hAAAA, 1);
        chk("full.mask2", bus.load_pending_mask, mexp(32'h3C));
        lsu_op(1, 6, 0);
        #1 chk("full.still4", bus.lsu_stall, 1);
        idle();
        for (int r = 2; r <= 5; r++) begin
            bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h100 + 32'(r);
            step();
            idle();
            chk_lsu("full.drain", 5'(r), 32'h100 + 32'(r), 1);
        end
        chk("full.mask_empty", bus.load_pending_mask, 0);

        // orphan response
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hBAD;
        step();
        idle();
        chk("orph.we", bus.lsu_rf_we, 0);
        chk("orph.rd", bus.lsu_wb_rd, 0);
        chk("orph.err", bus.lq_err, 1);
        step();
        chk("orph.sticky", bus.lq_err, 1);

        // asynchronous reset mid-stream, then a late response
        lsu_op(1, 12, 0);
        bus.ixu1_ex_valid = 1; bus.ixu1_ex_rd = 8; bus.ixu1_ex_data = 1;
        step();
        idle();
        chk("mrst.mask_pre", bus.load_pending_mask, mexp(32'h1000));
        #2 rst_n = 0;
        #1;
        chk("mrst.ixu1_rd", bus.ixu1_wb_rd, 0);
        chk("mrst.mask", bus.load_pending_mask, 0);
        chk("mrst.err", bus.lq_err, 0);
        @(negedge clk);
        rst_n = 1;
        step();
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h77;
        step();
        idle();
        chk("mrst.late_err", bus.lq_err, 1);
        chk("mrst.late_we", bus.lsu_rf_we, 0);

        // randomized phase against the reference model
        rst_n = 0;
        #3;
        @(negedge clk);
        rst_n = 1;
        step();
        q.delete();
        m_hold_v = 0; m_hold_rd = 0; m_hold_data = 0; m_err = 0;
        prev_stall = 0;
        lv = 0; il = 0; lrd = 0; ld = 0;
        for (int c = 0; c < 400; c++) begin
            if (!prev_stall) begin
                lv  = 1'($urandom_range(0, 1));
                il  = ($urandom_range(0, 2) != 0);
                lrd = 5'($urandom_range(0, 31));
                ld  = $urandom;
            end
            rsp = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            v1 = 1'($urandom_range(0, 1)); rd1 = 5'($urandom_range(0, 31)); d1 = $urandom;
            v2 = 1'($urandom_range(0, 1)); rd2 = 5'($urandom_range(0, 31)); d2 = $urandom;
            bus.ixu1_ex_valid = v1; bus.ixu1_ex_rd = rd1; bus.ixu1_ex_data = d1;
            bus.ixu2_ex_valid = v2; bus.ixu2_ex_rd = rd2; bus.ixu2_ex_data = d2;
            bus.lsu_ex_valid = lv; bus.lsu_ex_is_load = il; bus.lsu_ex_rd = lrd; bus.lsu_ex_data = ld;
            bus.mem_rsp_valid = rsp; bus.mem_rsp_data = $urandom;
            #1;
            e_stall = m_hold_v || (q.size() == DEPTH && lv && il && !rsp);
            chk("rnd.stall", bus.lsu_stall, e_stall);

            push = lv && il && !e_stall;
            pop  = rsp && (q.size() > 0);
            nl   = lv && !il && !e_stall;
            er = 0; ed = 0; ev = 0;
            if (pop) begin
                h  = q.pop_front();
                er = 5'(h);
                ed = (h != 0) ? bus.mem_rsp_data : 0;
                ev = 1;
                if (nl) begin
                    m_hold_v = 1; m_hold_rd = lrd; m_hold_data = (lrd != 0) ? ld : 0;
                end
            end else if (m_hold_v) begin
                er = m_hold_rd; ed = m_hold_data; m_hold_v = 0;
            end else if (nl) begin
                er = lrd; ed = (lrd != 0) ? ld : 0;
            end
            if (push) q.push_back(int'(lrd));
            prev_stall = e_stall;

            step();
            chk("rnd.ixu1_rd", bus.ixu1_wb_rd, v1 ? rd1 : 5'd0);
            chk("rnd.ixu1_data", bus.ixu1_wb_data, (v1 && rd1 != 0) ? d1 : 32'd0);
            chk("rnd.ixu1_we", bus.ixu1_rf_we, v1 && rd1 != 0);
            chk("rnd.ixu2_rd", bus.ixu2_wb_rd, v2 ? rd2 : 5'd0);
            chk("rnd.ixu2_data", bus.ixu2_wb_data, (v2 && rd2 != 0) ? d2 : 32'd0);
            chk("rnd.ixu2_we", bus.ixu2_rf_we, v2 && rd2 != 0);
            chk_lsu("rnd.lsu", er, ed, ev);
            m = 0;
            foreach (q[i]) m = m | (32'h1 << q[i]);
            m[0] = 1'b0;
            chk("rnd.mask", bus.load_pending_mask, mexp(m));
            chk("rnd.err", bus.lq_err, m_err);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for the VLIW pipeline. It registers execute-stage results from IXU1, IXU2 and the LSU, and drives the three register-file write ports. It also drives the writeback rd/data/is_load signals that the forwarding logic compares against execute source registers. Load data returns from memory with variable latency, so the block keeps an in-order queue of outstanding load destinations and exports a pending-register mask for load-use stall decisions in issue.

## Interface
- `LQ_DEPTH`, 4: outstanding-load queue entries (power of two, ≥2).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ixu1_ex_valid`, `ixu2_ex_valid` in 1: IXU result valid this cycle.
- `ixu1_ex_rd`, `ixu2_ex_rd` in 5: IXU destination register.
- `ixu1_ex_data`, `ixu2_ex_data` in 32: IXU result.
- `lsu_ex_valid` in 1: LSU op leaving execute.
- `lsu_ex_is_load` in 1: 1 = load (data comes later); 0 = LSU result written now.
- `lsu_ex_rd` in 5: LSU destination register.
- `lsu_ex_data` in 32: non-load LSU result.
- `mem_rsp_valid` in 1: load data returning; responses arrive in issue order.
- `mem_rsp_data` in 32: returned load data.
- `ixu1_wb_rd`, `ixu2_wb_rd`, `lsu_wb_rd` out 5: writeback destination; 0 when the slot is idle.
- `ixu1_wb_data`, `ixu2_wb_data`, `lsu_wb_data` out 32: writeback data; 0 when the matching rd is 0.
- `lsu_wb_is_load` out 1: the LSU slot this cycle carries load data.
- `ixu1_rf_we`, `ixu2_rf_we`, `lsu_rf_we` out 1: register-file write enables.
- `lsu_stall` out 1: LSU execute must hold its op this cycle.
- `load_pending_mask` out 32: bit r = a queued load targets xr.
- `lq_err` out 1: sticky; a response arrived with the queue empty.

## Operation
- **IXU slots:** each slot is a plain pipeline register.
  - `*_wb_rd` is `ex_valid ? ex_rd : 0`.
  - `*_wb_data` is the data when the registered rd ≠ 0, otherwise 0.
  - `rf_we` = (registered rd ≠ 0).
- **Load queue:** circular buffer of 5-bit rd with read/write pointers and a count.
  - Push when `lsu_ex_valid & lsu_ex_is_load & !lsu_stall`.
  - Pop when `mem_rsp_valid` and count > 0.
  - Loads to x0 are pushed so they consume their response, but they never assert `rf_we`.
- **LSU slot priority:**
  1. Load response (head rd, `mem_rsp_data`, `is_load`=1).
  2. Hold register (non-load result parked earlier).
  3. Direct non-load result from execute.
- **Hold register (1 entry):** captures a non-load LSU result that loses to a load response in the same cycle. The hold register drains on the next cycle with no response.
- **`lsu_stall`** (combinational) = `hold_valid | (count==LQ_DEPTH & lsu_ex_valid & lsu_ex_is_load & !mem_rsp_valid)`.
- **Full queue:** a simultaneous push and pop is allowed; count is unchanged and no stall is raised.
- **`load_pending_mask`:** OR of one-hot(rd) over valid queue entries, with bit 0 forced to 0. It is combinational from state only.
- **`lq_err`:** set when `mem_rsp_valid` arrives with count = 0; the response is discarded and no write occurs. Only reset clears it.

## Timing
- Reset values:
  - All `*_wb_rd`, `*_wb_data`, `*_rf_we`, and `lsu_wb_is_load` = 0.
  - Queue empty, hold empty, `load_pending_mask` = 0, `lq_err` = 0.
- Reset mid-operation clears all queued loads; their late responses then raise `lq_err`.
- Latencies:
  - IXU and non-load LSU: execute cycle N → writeback outputs valid in N+1.
  - Load: response in cycle M → `lsu_wb_*` valid in M+1.
- Mask timing: the mask bit sets in the cycle after the push. It clears in the cycle after the pop, which is the same cycle the data appears on the writeback port.
- `lsu_stall` depends on current inputs and state only. Execute must hold its inputs stable while the stall is high.

## Configuration
- `WB_LOAD_PENDING_MASK_EN` defined: `load_pending_mask` is computed as described above.
- `WB_LOAD_PENDING_MASK_EN` undefined: `load_pending_mask` is tied to 32'h0, and the mask logic is not built. Issue must then stall on any outstanding load by its own means. The queue and all other behaviour are unchanged.

## Test plan
- **IXU writeback:** `ixu1_ex` {valid=1, rd=5, data=0xDEAD} and `ixu2_ex` {valid=1, rd=0, data=0x1234} → next cycle `ixu1_wb_rd`=5, data=0xDEAD, we=1; `ixu2_wb_rd`=0, data=0, we=0.
- **Load path:** load to rd=7 pushed → `load_pending_mask`=0x80 next cycle. `mem_rsp` data=0xCAFE three cycles later → next cycle `lsu_wb_rd`=7, data=0xCAFE, `is_load`=1, we=1, mask=0.
- **Response vs non-load collision:** non-load LSU result rd=3/0x11 in the same cycle as a response to a queued load rd=9 → load written first with `lsu_stall`=1 for one cycle, then rd=3/0x11 written with `is_load`=0.
- **Full queue:** four loads (rd 1–4) queued → fifth load sees `lsu_stall`=1. The same fifth load issued together with `mem_rsp_valid` → no stall; count stays 4; mask goes 0x1E→0x3C.
- **Orphan response:** `mem_rsp_valid` with empty queue → no write; `lq_err`=1 and stays set. Asserting `rst_n`=0 mid-stream clears the queue, outputs and `lq_err` asynchronously.
